regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_init_ctr.sv | 41 ++++
 rtl/regfile_param.sv | 137 +++++++++++++
 tb/tb_regfile_param.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file.
// Contents:
//   DATA_W_DEFAULT / ADDR_W_DEFAULT : default word and address widths
//   state_e                         : controller states (ST_INIT clears, ST_RUN serves)
package regfile_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 5;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_init_ctr.sv
// Clear-sequence address counter for the register file.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset, forces the counter to 0
//   en_i   : count enable (high while the register file is clearing)
//   cnt_o  : entry currently being cleared
//   done_o : high in the cycle the last entry (DEPTH-1) is cleared
module regfile_init_ctr #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // The counter wraps to 0 after the last entry, so it is already at 0
    // when the controller leaves the clear sequence.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = en_i && (cnt_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/regfile_param.sv
// Parameterised two-read / one-write register file with a power-up clear
// sequence and write-first bypass.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   rs1, rs2  : read addresses; rf requests a read on both ports
//   ws, wd    : write address and data; wf requests a write
//   rd1, rd2  : registered read data, held when no read is requested
//   rd_valid  : one-cycle strobe marking rd1/rd2 as fresh read data
//   ready     : high once the clear sequence has finished
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              rf,
    input  logic [ADDR_W-1:0] ws,
    input  logic [DATA_W-1:0] wd,
    input  logic              wf,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd_valid,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q;
    state_e            state_d;
    logic              rd_valid_q;
    logic              rd_valid_d;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_done;
    logic              run;
    logic              wr_en;
    logic              rd_en;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0][ADDR_W-1:0] rs_addr;
    logic [1:0][DATA_W-1:0] rd_data;

    regfile_init_ctr #(
        .ADDR_W (ADDR_W)
    ) u_init_ctr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == ST_INIT),
        .cnt_o  (clr_addr),
        .done_o (clr_done)
    );

    assign run = (state_q == ST_RUN);

    // A write to entry 0 is dropped when it is hard-wired to zero; gating it
    // here also keeps entry 0 out of the bypass path.
    assign wr_en = run && wf && !((ZERO_R0 != 0) && (ws == '0));
    assign rd_en = run && rf;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (clr_done) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        rd_valid_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Sole writer of the storage array: clear sequence in INIT, user writes
    // in RUN. Nothing is written in a reset cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                mem[clr_addr] <= '0;
            end else if (wr_en) begin
                mem[ws] <= wd;
            end
        end
    end

    assign rs_addr = {rs2, rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_rd_port
            logic [DATA_W-1:0] rd_q;
            logic [DATA_W-1:0] rd_d;
            logic              hit_zero;
            logic              hit_bypass;

            assign hit_zero   = (ZERO_R0 != 0) && (rs_addr[gi] == '0);
            assign hit_bypass = wr_en && (ws == rs_addr[gi]);

            // Write-first: a same-cycle write to the read address wins over
            // the stored value; the hard-wired zero wins over everything.
            always_comb begin
                rd_d = mem[rs_addr[gi]];
                if (hit_bypass) rd_d = wd;
                if (hit_zero)   rd_d = '0;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= rd_d;
                end
            end

            assign rd_data[gi] = rd_q;
        end
    endgenerate

    assign rd1      = rd_data[0];
    assign rd2      = rd_data[1];
    assign rd_valid = rd_valid_q;
    assign ready    = run;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic [AW-1:0] ws  = '0;
    logic          rf  = 1'b0;
    logic          wf  = 1'b0;
    logic [DW-1:0] wd  = '0;

    logic [DW-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic          a_v, b_v, a_rdy, b_rdy;

    int errors = 0;
    int checks = 0;

    logic [2*DW-1:0] qa[$];
    logic [2*DW-1:0] qb[$];
    logic [2*DW-1:0] ea, eb;

    initial forever #5 clk = ~clk;

    // Instance a: entry 0 is an ordinary register. Instance b: entry 0 reads zero.
    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0)) dut_a (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rf(rf), .ws(ws), .wd(wd), .wf(wf),
        .rd1(a_rd1), .rd2(a_rd2), .rd_valid(a_v), .ready(a_rdy)
    );

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1)) dut_b (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rf(rf), .ws(ws), .wd(wd), .wf(wf),
        .rd1(b_rd1), .rd2(b_rd2), .rd_valid(b_v), .ready(b_rdy)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request cycle; a read pushes its expected result for each instance.
    task automatic issue(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wdat,
                         input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [DW-1:0] ea1, input logic [DW-1:0] ea2,
                         input logic [DW-1:0] eb1, input logic [DW-1:0] eb2);
        wf = w; ws = wa; wd = wdat; rf = r; rs1 = a1; rs2 = a2;
        if (r) begin
            qa.push_back({ea1, ea2});
            qb.push_back({eb1, eb2});
        end
        step();
        wf = 1'b0;
        rf = 1'b0;
    endtask

    // Counts cycles from now until ready rises, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!a_rdy && n < 100) begin
            step();
            n++;
        end
    endtask

    // Monitor: every rd_valid pops one expected entry per instance.
    always @(negedge clk) begin
        if (a_v === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_valid: got unexpected rd_valid rd1=%h required no read", a_rd1);
            end else begin
                ea = qa.pop_front();
                check("a_rd1", a_rd1, ea[2*DW-1:DW]);
                check("a_rd2", a_rd2, ea[DW-1:0]);
            end
        end
        if (b_v === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_valid: got unexpected rd_valid rd1=%h required no read", b_rd1);
            end else begin
                eb = qb.pop_front();
                check("b_rd1", b_rd1, eb[2*DW-1:DW]);
                check("b_rd2", b_rd2, eb[DW-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Reset state.
        step(); step(); step();
        check("rst_ready_a", {31'd0, a_rdy}, 32'd0);
        check("rst_valid_a", {31'd0, a_v},   32'd0);
        check("rst_rd1_a",   a_rd1,          32'd0);
        check("rst_rd2_a",   a_rd2,          32'd0);
        check("rst_ready_b", {31'd0, b_rdy}, 32'd0);

        // Release reset with requests pending through the whole clear sequence.
        rst = 1'b0;
        wf = 1'b1; ws = 5'd3; wd = 32'd1;
        rf = 1'b1; rs1 = 5'd3; rs2 = 5'd3;
        wait_ready(n);
        wf = 1'b0; rf = 1'b0;
        check("init_cycles", n, 32'd32);
        check("init_ready_b", {31'd0, b_rdy}, 32'd1);

        // Every entry reads zero after the clear sequence, back to back.
        for (int a = 0; a < 32; a++) begin
            issue(1'b0, '0, '0, 1'b1, AW'(a), AW'(31 - a), '0, '0, '0, '0);
        end

        // Write then read next cycle, then hold with rf=0.
        issue(1'b1, 5'd5, 32'h3F800000, 1'b0, '0, '0, '0, '0, '0, '0);
        issue(1'b0, '0, '0, 1'b1, 5'd5, 5'd0, 32'h3F800000, 32'd0, 32'h3F800000, 32'd0);
        issue(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0, '0);
        check("hold_valid", {31'd0, a_v}, 32'd0);
        check("hold_rd1_a", a_rd1, 32'h3F800000);
        check("hold_rd1_b", b_rd1, 32'h3F800000);

        // Same-cycle write/read of one address on both ports.
        issue(1'b1, 5'd7, 32'h41100000, 1'b1, 5'd7, 5'd7,
              32'h41100000, 32'h41100000, 32'h41100000, 32'h41100000);

        // Entry 0 behaviour, stored and bypassed.
        issue(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, '0, '0, '0, '0, '0, '0);
        issue(1'b0, '0, '0, 1'b1, 5'd0, 5'd5, 32'hDEADBEEF, 32'h3F800000, 32'd0, 32'h3F800000);
        issue(1'b1, 5'd0, 32'hCAFEF00D, 1'b1, 5'd0, 5'd7, 32'hCAFEF00D, 32'h41100000, 32'd0, 32'h41100000);

        // Back-to-back writes and reads with bypass on either port.
        issue(1'b1, 5'd10, 32'hA5A5A5A5, 1'b1, 5'd10, 5'd7,
              32'hA5A5A5A5, 32'h41100000, 32'hA5A5A5A5, 32'h41100000);
        issue(1'b1, 5'd11, 32'h5A5A5A5A, 1'b1, 5'd10, 5'd11,
              32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A);
        issue(1'b1, 5'd12, 32'h11112222, 1'b1, 5'd5, 5'd12,
              32'h3F800000, 32'h11112222, 32'h3F800000, 32'h11112222);
        issue(1'b0, '0, '0, 1'b1, 5'd0, 5'd11, 32'hCAFEF00D, 32'h5A5A5A5A, 32'd0, 32'h5A5A5A5A);
        issue(1'b1, 5'd31, 32'h12345678, 1'b1, 5'd31, 5'd10,
              32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5);
        issue(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0, '0);

        // Reset in RUN with a request in the same cycle: request is dropped.
        rst = 1'b1;
        wf = 1'b1; ws = 5'd31; wd = 32'hFFFF0000;
        rf = 1'b1; rs1 = 5'd31; rs2 = 5'd31;
        step();
        check("rrst_rd1",   a_rd1, 32'd0);
        check("rrst_rd2",   a_rd2, 32'd0);
        check("rrst_valid", {31'd0, a_v}, 32'd0);
        check("rrst_ready", {31'd0, a_rdy}, 32'd0);
        step(); step();
        check("rrst_hold_ready", {31'd0, a_rdy}, 32'd0);
        rst = 1'b0;
        wf = 1'b0; rf = 1'b0;
        wait_ready(n);
        check("rrst_init_cycles", n, 32'd32);

        issue(1'b0, '0, '0, 1'b1, 5'd31, 5'd5, '0, '0, '0, '0);
        issue(1'b0, '0, '0, 1'b1, 5'd0, 5'd3, '0, '0, '0, '0);

        step(); step(); step();
        check("queue_a_left", qa.size(), 32'd0);
        check("queue_b_left", qb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
